// File: rtl/fm_audio_conditioner_pkg.sv
// Shared types and constants for the FM audio conditioner.
package audio_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        UNMUTED   = 2'd2,
        RAMP_DOWN = 2'd3
    } mute_state_t;

    // Unity gain on the 0..256 gain scale; the gain word is 9 bits unsigned.
    localparam logic [8:0] GAIN_ONE = 9'd256;

endpackage : audio_pkg

// File: rtl/fm_audio_conditioner_iir.sv
// deemphasis_iir: first-order low-pass, acc += x - acc/2^SHIFT, y = acc/2^SHIFT.
// SHIFT = 0 degenerates to a plain one-cycle register (y = x delayed).
module deemphasis_iir #(
    parameter int WIDTH = 18,
    parameter int SHIFT = 3
) (
    input  logic                    clk_audio,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] x_i,
    output logic signed [WIDTH-1:0] y_o
);

    localparam int ACC_W = WIDTH + SHIFT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W:0]   sum_w;

    assign acc_shr = acc_q >>> SHIFT;
    assign y_o     = WIDTH'(acc_shr);

    // Next accumulator value; one guard bit absorbs the transient before the leak term.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
        sum_w = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(x_i) - (ACC_W + 1)'(acc_shr);
        acc_d = ACC_W'(sum_w);
    end

    // Accumulator register, cleared by reset.
    always_ff @(posedge clk_audio) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : deemphasis_iir

// File: rtl/fm_audio_conditioner.sv
// fm_audio_conditioner: L/R matrix, de-emphasis, soft-mute gain ramp and
// underrun hold; one stereo frame per clk_audio cycle, registered output.
module fm_audio_conditioner
    import audio_pkg::*;
#(
    parameter int IN_WIDTH        = 18,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int DEEMPH_SHIFT    = 3,
    parameter int RAMP_STEP       = 1,
    parameter int UNDERRUN_LIMIT  = 8
) (
    input  logic                              clk_audio,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic signed [IN_WIDTH-1:0]        in_sum,
    input  logic signed [IN_WIDTH-1:0]        in_diff,
    input  logic                              stereo_enable,
    input  logic                              mute,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0]   audio_sample_word,
    output logic                              muted,
    output logic                              underrun,
    output logic [15:0]                       underrun_count
);

    localparam int                MATRIX_W  = IN_WIDTH + 1;
    localparam int                PROD_W    = IN_WIDTH + 10;
    localparam int                OUT_SHIFT = 8 + IN_WIDTH - AUDIO_BIT_WIDTH;
    localparam int                MISS_W    = $clog2(UNDERRUN_LIMIT + 1);
    localparam logic [8:0]        GAIN_STEP = 9'(RAMP_STEP);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(UNDERRUN_LIMIT);

    // ---------------- stage 1: matrix and sample hold ----------------
    // The matrixed pair is held rather than raw S/D, so stereo_enable only
    // takes effect when a new sample is captured.
    logic signed [MATRIX_W-1:0] sum_ext, diff_ext, l_wide, r_wide;
    logic signed [IN_WIDTH-1:0] hold_l_q, hold_r_q;
    logic signed [IN_WIDTH-1:0] hold_l_d, hold_r_d;

    // Matrix at IN_WIDTH+1 bits; the floored halving brings it back into IN_WIDTH.
    always_comb begin
        sum_ext  = MATRIX_W'(in_sum);
        diff_ext = MATRIX_W'(in_diff);
        if (stereo_enable) begin
            l_wide = (sum_ext + diff_ext) >>> 1;
            r_wide = (sum_ext - diff_ext) >>> 1;
        end else begin
            l_wide = sum_ext >>> 1;
            r_wide = sum_ext >>> 1;
        end
        hold_l_d = in_valid ? IN_WIDTH'(l_wide) : hold_l_q;
        hold_r_d = in_valid ? IN_WIDTH'(r_wide) : hold_r_q;
    end

    // Sample hold: a missing sample keeps feeding the last good one downstream.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
        end
    end

    // ---------------- stage 2: de-emphasis ----------------
    logic signed [IN_WIDTH-1:0] y_l, y_r;

    deemphasis_iir #(.WIDTH(IN_WIDTH), .SHIFT(DEEMPH_SHIFT)) u_iir_l (
        .clk_audio (clk_audio),
        .reset     (reset),
        .x_i       (hold_l_q),
        .y_o       (y_l)
    );

    deemphasis_iir #(.WIDTH(IN_WIDTH), .SHIFT(DEEMPH_SHIFT)) u_iir_r (
        .clk_audio (clk_audio),
        .reset     (reset),
        .x_i       (hold_r_q),
        .y_o       (y_r)
    );

    // ---------------- stage 3: gain ----------------
    logic [8:0]                        gain_q;
    logic signed [9:0]                 gain_s;
    logic signed [PROD_W-1:0]          prod_l, prod_r;
    logic [1:0][AUDIO_BIT_WIDTH-1:0]   word_d, word_q;

    assign gain_s = signed'({1'b0, gain_q});

    // Scale by gain/256 and keep the top AUDIO_BIT_WIDTH bits of the IN_WIDTH result (floor).
    always_comb begin
        prod_l    = PROD_W'(y_l) * PROD_W'(gain_s);
        prod_r    = PROD_W'(y_r) * PROD_W'(gain_s);
        word_d[0] = AUDIO_BIT_WIDTH'(prod_l >>> OUT_SHIFT);
        word_d[1] = AUDIO_BIT_WIDTH'(prod_r >>> OUT_SHIFT);
    end

    // Output register sampled by the packet picker every cycle.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    // ---------------- underrun detection ----------------
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       underrun_count_q;

    // Saturating miss counter; a valid sample restarts it.
    always_comb begin
        if (in_valid) begin
            miss_d = '0;
        end else if (miss_q == MISS_MAX) begin
            miss_d = miss_q;
        end else begin
            miss_d = miss_q + MISS_W'(1);
        end
        underrun_d = (miss_d == MISS_MAX);
    end

    // Underrun flag and saturating count of its rising edges.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            miss_q           <= '0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            miss_q     <= miss_d;
            underrun_q <= underrun_d;
            if (underrun_d && !underrun_q && (underrun_count_q != 16'hFFFF)) begin
                underrun_count_q <= underrun_count_q + 16'd1;
            end
        end
    end

    // ---------------- soft-mute FSM ----------------
    mute_state_t state_q;
    mute_state_t up_state, down_state;
    logic        muted_q;
    logic        mute_req;
    logic [8:0]  gain_up, gain_dn;

    assign mute_req = mute | underrun_q;

    // One-step gain candidates, clamped to 0..GAIN_ONE.
    always_comb begin
        gain_up    = (gain_q >= (GAIN_ONE - GAIN_STEP)) ? GAIN_ONE : (gain_q + GAIN_STEP);
        gain_dn    = (gain_q <= GAIN_STEP) ? 9'd0 : (gain_q - GAIN_STEP);
        up_state   = (gain_up == GAIN_ONE) ? UNMUTED : RAMP_UP;
        down_state = (gain_dn == 9'd0) ? MUTED : RAMP_DOWN;
    end

    // Mute FSM: state, gain and muted flag all move on the same edge.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            state_q <= MUTED;
            gain_q  <= '0;
            muted_q <= 1'b1;
        end else begin
            unique case (state_q)
                MUTED: begin
                    if (!mute_req) begin
                        state_q <= up_state;
                        gain_q  <= gain_up;
                        muted_q <= 1'b0;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (mute_req) begin
                        state_q <= down_state;
                        gain_q  <= gain_dn;
                        muted_q <= (gain_dn == 9'd0);
                    end else begin
                        state_q <= up_state;
                        gain_q  <= gain_up;
                        muted_q <= 1'b0;
                    end
                end
                UNMUTED: begin
                    if (mute_req) begin
                        state_q <= down_state;
                        gain_q  <= gain_dn;
                        muted_q <= (gain_dn == 9'd0);
                    end
                end
            endcase
        end
    end

    assign audio_sample_word = word_q;
    assign muted             = muted_q;
    assign underrun          = underrun_q;
    assign underrun_count    = underrun_count_q;

endmodule : fm_audio_conditioner

// File: tb/tb_fm_audio_conditioner.sv
// Scoreboard bench: two conditioner instances (fast ramp / no de-emphasis and
// slow ramp / de-emphasis) share stimulus; an arithmetic reference model
// pushes expected outputs, a negedge monitor pops and compares.
module tb_fm_audio_conditioner;

    localparam int IW  = 18;
    localparam int AW  = 16;
    localparam int LIM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 vld = 1'b0;
    logic                 ste = 1'b1;
    logic                 mu  = 1'b0;
    logic signed [IW-1:0] s_in = '0;
    logic signed [IW-1:0] d_in = '0;

    logic [1:0][AW-1:0] word_a, word_b;
    logic               muted_a, muted_b, und_a, und_b;
    logic [15:0]        cnt_a, cnt_b;

    fm_audio_conditioner #(.IN_WIDTH(IW), .AUDIO_BIT_WIDTH(AW), .DEEMPH_SHIFT(0),
                           .RAMP_STEP(256), .UNDERRUN_LIMIT(LIM)) dut_a (
        .clk_audio(clk), .reset(rst), .in_valid(vld), .in_sum(s_in), .in_diff(d_in),
        .stereo_enable(ste), .mute(mu), .audio_sample_word(word_a),
        .muted(muted_a), .underrun(und_a), .underrun_count(cnt_a)
    );

    fm_audio_conditioner #(.IN_WIDTH(IW), .AUDIO_BIT_WIDTH(AW), .DEEMPH_SHIFT(3),
                           .RAMP_STEP(1), .UNDERRUN_LIMIT(LIM)) dut_b (
        .clk_audio(clk), .reset(rst), .in_valid(vld), .in_sum(s_in), .in_diff(d_in),
        .stereo_enable(ste), .mute(mu), .audio_sample_word(word_b),
        .muted(muted_b), .underrun(und_b), .underrun_count(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint hold_l, hold_r, acc_l, acc_r, gain, out_l, out_r;
        int     miss, ucnt;
        bit     und;
    } model_t;

    typedef struct packed {
        logic [AW-1:0] l;
        logic [AW-1:0] r;
        logic          m;
        logic          u;
        logic [15:0]   c;
    } exp_t;

    model_t mdl [2];
    int     shift_p [2] = '{0, 3};
    int     step_p  [2] = '{256, 1};
    exp_t   q_a [$];
    exp_t   q_b [$];

    // Advance instance k's model by one clock edge using the inputs present now.
    task automatic model_edge(input int k);
        model_t o, n;
        exp_t   e;
        longint s, d, ml, mr;
        bit     req;
        o = mdl[k];
        n = o;
        if (rst) begin
            n.hold_l = 0; n.hold_r = 0; n.acc_l = 0; n.acc_r = 0; n.gain = 0;
            n.out_l = 0; n.out_r = 0; n.miss = 0; n.ucnt = 0; n.und = 0;
        end else begin
            // output = floor(y * gain / 256) expressed on the top AW of IW bits
            n.out_l = ((o.acc_l >>> shift_p[k]) * o.gain) >>> (8 + IW - AW);
            n.out_r = ((o.acc_r >>> shift_p[k]) * o.gain) >>> (8 + IW - AW);
            n.acc_l = o.acc_l + o.hold_l - (o.acc_l >>> shift_p[k]);
            n.acc_r = o.acc_r + o.hold_r - (o.acc_r >>> shift_p[k]);
            if (vld) begin
                s = longint'(s_in);
                d = longint'(d_in);
                ml = ste ? ((s + d) >>> 1) : (s >>> 1);
                mr = ste ? ((s - d) >>> 1) : (s >>> 1);
                n.hold_l = ml;
                n.hold_r = mr;
            end
            req = mu || o.und;
            if (req) n.gain = (o.gain - step_p[k] < 0) ? 0 : o.gain - step_p[k];
            else     n.gain = (o.gain + step_p[k] > 256) ? 256 : o.gain + step_p[k];
            n.miss = vld ? 0 : ((o.miss + 1 > LIM) ? LIM : o.miss + 1);
            n.und  = (n.miss == LIM);
            if (n.und && !o.und && o.ucnt < 65535) n.ucnt = o.ucnt + 1;
        end
        mdl[k] = n;
        e.l = AW'(n.out_l);
        e.r = AW'(n.out_r);
        e.m = (n.gain == 0);
        e.u = n.und;
        e.c = 16'(n.ucnt);
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // One clock edge: update the model right after the edge, then move off it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    // Output is presented every cycle; compare each expected frame on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("A_L", 64'(word_a[0]), 64'(e.l));
            check("A_R", 64'(word_a[1]), 64'(e.r));
            check("A_muted", 64'(muted_a), 64'(e.m));
            check("A_underrun", 64'(und_a), 64'(e.u));
            check("A_underrun_count", 64'(cnt_a), 64'(e.c));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("B_L", 64'(word_b[0]), 64'(e.l));
            check("B_R", 64'(word_b[1]), 64'(e.r));
            check("B_muted", 64'(muted_b), 64'(e.m));
            check("B_underrun", 64'(und_b), 64'(e.u));
            check("B_underrun_count", 64'(cnt_b), 64'(e.c));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        step(2);
        check("reset_A_L", 64'(word_a[0]), 64'h0);
        check("reset_A_muted", 64'(muted_a), 64'h1);

        // Unity gain after one edge, steady L=R=0x2000 for S=0x10000
        rst = 1'b0; mu = 1'b0; ste = 1'b1; vld = 1'b1; s_in = 18'h10000; d_in = '0;
        step(1);
        check("A_unmute_1edge", 64'(muted_a), 64'h0);
        step(5);
        check("A_steady_L", 64'(word_a[0]), 64'h2000);
        check("A_steady_R", 64'(word_a[1]), 64'h2000);

        // Stereo step; output changes on the third edge counting the capture edge
        s_in = 18'sd4000; d_in = 18'sd2000;
        step(2);
        check("A_latency_old", 64'(word_a[0]), 64'h2000);
        step(1);
        check("A_stereo_L", 64'(word_a[0]), 64'd750);
        check("A_stereo_R", 64'(word_a[1]), 64'd250);
        ste = 1'b0;
        step(2);
        check("A_mono_old", 64'(word_a[0]), 64'd750);
        step(1);
        check("A_mono_L", 64'(word_a[0]), 64'd500);
        check("A_mono_R", 64'(word_a[1]), 64'd500);

        // De-emphasis step response on B: settle at zero, then L=8000
        ste = 1'b1; s_in = '0; d_in = '0;
        step(40);
        s_in = 18'sd16000;
        step(60);

        // Bring B to unity, then ramp it down over 256 edges
        step(300);
        mu = 1'b1;
        step(255);
        check("B_gain1_not_muted", 64'(muted_b), 64'h0);
        step(1);
        check("B_gain0_muted", 64'(muted_b), 64'h1);
        mu = 1'b0;
        step(1);
        check("B_rampup_start", 64'(muted_b), 64'h0);
        step(99);
        mu = 1'b1;
        step(10);
        mu = 1'b0;
        step(300);

        // Underrun: eight missing samples
        vld = 1'b0;
        step(7);
        check("A_no_underrun_7", 64'(und_a), 64'h0);
        step(1);
        check("A_underrun_8", 64'(und_a), 64'h1);
        check("A_underrun_count", 64'(cnt_a), 64'h1);
        step(1);
        check("A_underrun_mutes", 64'(muted_a), 64'h1);
        vld = 1'b1;
        step(1);
        check("A_underrun_clear", 64'(und_a), 64'h0);
        step(1);
        check("A_underrun_rampup", 64'(muted_a), 64'h0);

        // Randomised traffic with bursts of dropped samples and mute toggles
        for (int i = 0; i < 400; i++) begin
            vld  = ((i % 100) >= 88) ? 1'b0 : ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 39) == 0) mu = ~mu;
            if ($urandom_range(0, 19) == 0) ste = ~ste;
            s_in = IW'(int'($urandom_range(0, 131070)) - 65535);
            d_in = IW'(int'($urandom_range(0, 131070)) - 65535);
            step(1);
        end

        // Reset in the middle of B's ramp-down
        mu = 1'b0; ste = 1'b1; vld = 1'b1; s_in = 18'h10000; d_in = '0;
        step(300);
        mu = 1'b1;
        step(20);
        rst = 1'b1;
        step(1);
        check("rst_B_L", 64'(word_b[0]), 64'h0);
        check("rst_B_R", 64'(word_b[1]), 64'h0);
        check("rst_B_muted", 64'(muted_b), 64'h1);
        check("rst_A_count", 64'(cnt_a), 64'h0);
        check("rst_B_underrun", 64'(und_b), 64'h0);
        rst = 1'b0; mu = 1'b0;
        step(3);

        @(negedge clk);
        #1;
        check("scoreboard_drained_A", 64'(q_a.size()), 64'h0);
        check("scoreboard_drained_B", 64'(q_b.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fm_audio_conditioner
